// File: rtl/digit_serial_addsub_pkg.sv
// arith_pkg: shared state encoding and parameter helpers for the digit-serial add/sub unit.
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic bit params_ok(input int width, input int digit);
    return (digit >= 1) && (width >= 2) && (width % digit == 0);
  endfunction
endpackage

// File: rtl/digit_serial_addsub_digit_adder.sv
// digit_adder: combinational DIGIT-bit adder exposing the carry into its top bit for overflow detection.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  assign {cout, s} = (DIGIT+1)'(a) + (DIGIT+1)'(b) + (DIGIT+1)'(cin);
  assign c_msb = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: LSB-first add/subtract of two WIDTH-bit operands, DIGIT bits per clock.
module digit_serial_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] ds;
  logic             dc, dm;
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .cin(carry_q),
    .s(ds), .cout(dc), .c_msb(dm)
  );
  // Subtraction is a + ~b + ~borrow, so only the operand load differs between modes.
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    c_out_d = c_out_q;
    ovf_d = ovf_q;
    if (state_q == RUN) begin
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      r_d = (r_q >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
      carry_d = dc;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d = DONE;
        sum_d = r_d;
        c_out_d = dc;
        ovf_d = dc ^ dm;
      end
    end else if (start) begin
      state_d = RUN;
      a_d = a_in;
      b_d = sub ? ~b_in : b_in;
      carry_d = sub ^ c_in;
      cnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      c_out_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      c_out_q <= c_out_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy  = state_q == RUN;
  assign done  = state_q == DONE;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: scoreboard bench for a DIGIT=1 and a DIGIT=4 instance of the 8-bit unit.
module tb_digit_serial_addsub;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_v, sub_v, c_v, busy_v, done_v, cout_v, ovf_v;
  logic [7:0] a_v[2], b_v[2], sum_v[2];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       q[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
    .c_in(c_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .c_out(cout_v[0]), .ovf(ovf_v[0])
  );
  digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
    .c_in(c_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .c_out(cout_v[1]), .ovf(ovf_v[1])
  );

  function automatic int nd(input int u);
    return (u != 0) ? 2 : 8;
  endfunction

  // Reference: plain integer arithmetic, unsigned for sum/carry and signed for overflow.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    exp_t e;
    int   r, rs;
    r  = s ? int'(a) - int'(b) - int'(c) : int'(a) + int'(b) + int'(c);
    rs = s ? int'($signed(a)) - int'($signed(b)) - int'(c) : int'($signed(a)) + int'($signed(b)) + int'(c);
    e.s = r[7:0];
    e.c = s ? (r >= 0) : (r > 255);
    e.v = (rs < -128) || (rs > 127);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Call at a negedge; returns at the negedge after the start edge.
  task automatic issue(input int u, input logic [7:0] av, input logic [7:0] bv, input logic sv, input logic cv);
    exp_t e;
    int   t = 0;
    while (busy_v[u] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d_issue_wait", u), 32'(t < 100), 1);
    a_v[u] = av;
    b_v[u] = bv;
    sub_v[u] = sv;
    c_v[u] = cv;
    start_v[u] = 1'b1;
    e = model(av, bv, sv, cv);
    e.cyc = cyc + 1 + nd(u);
    q[u].push_back(e);
    @(negedge clk);
    start_v[u] = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    int         bcnt = 0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        bcnt = 0;
        held = '0;
      end else if (done_v[g]) begin
        chk($sformatf("u%0d_done_expected", g), 32'(q[g].size() != 0), 1);
        if (q[g].size() != 0) begin
          e = q[g].pop_front();
          chk($sformatf("u%0d_sum", g), 32'(sum_v[g]), 32'(e.s));
          chk($sformatf("u%0d_c_out", g), 32'(cout_v[g]), 32'(e.c));
          chk($sformatf("u%0d_ovf", g), 32'(ovf_v[g]), 32'(e.v));
          chk($sformatf("u%0d_done_cycle", g), 32'(cyc), 32'(e.cyc));
          chk($sformatf("u%0d_busy_cycles", g), 32'(bcnt), 32'(nd(g)));
        end
        held = sum_v[g];
        bcnt = 0;
      end else begin
        chk($sformatf("u%0d_sum_hold", g), 32'(sum_v[g]), 32'(held));
        if (busy_v[g]) bcnt++;
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    start_v = '0;
    sub_v = '0;
    c_v = '0;
    a_v = '{default: '0};
    b_v = '{default: '0};
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_reset_outs", u), {busy_v[u], done_v[u], cout_v[u], ovf_v[u], sum_v[u]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    issue(0, 8'h35, 8'h4A, 1'b0, 1'b0);
    issue(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b1);
    issue(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    issue(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    issue(0, 8'h10, 8'h20, 1'b1, 1'b0);
    issue(0, 8'h80, 8'h01, 1'b1, 1'b0);
    issue(0, 8'h35, 8'h4A, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a_v[0] = 8'hAA;
    b_v[0] = 8'h55;
    sub_v[0] = 1'b1;
    c_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("u0_midrun_reset_outs", {busy_v[0], done_v[0], cout_v[0], ovf_v[0], sum_v[0]}, 0);
    q[0].delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(0, 8'h01, 8'h01, 1'b0, 1'b0);
    repeat (30) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (30) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    t = 0;
    while ((q[0].size() + q[1].size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(q[0].size() + q[1].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
